// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PCSrc encodings and the interrupt-entry FSM states.
package cpu_pkg;

  localparam logic [2:0] PCSRC_SEQ   = 3'd0;
  localparam logic [2:0] PCSRC_BR    = 3'd1;
  localparam logic [2:0] PCSRC_J     = 3'd2;
  localparam logic [2:0] PCSRC_JR    = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP = 3'd4;
  localparam logic [2:0] PCSRC_IRQ   = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PEND    = 2'd1,
    ST_HANDLER = 2'd2
  } irq_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The master side is the datapath, the slave side is hazard_ctrl.
// Counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;

  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       use_rt_id;
  logic [2:0] pcsrc_id;
  logic       iret_id;
  logic       memrd_ex;
  logic [4:0] wreg_ex;
  logic [2:0] pcsrc_ex;
  logic       br_taken_ex;
  logic       mem_busy;
  logic       irq;
  logic       stall_pc;
  logic       stall_if2id;
  logic       flush_if2id;
  logic       flush_id2ex;
  logic       irq_take;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    output rs_id, rt_id, use_rt_id, pcsrc_id, iret_id,
    output memrd_ex, wreg_ex, pcsrc_ex, br_taken_ex, mem_busy, irq,
    input  stall_pc, stall_if2id, flush_if2id, flush_id2ex, irq_take
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, input flush_cnt
`endif
  );

  modport slave (
    input  rs_id, rt_id, use_rt_id, pcsrc_id, iret_id,
    input  memrd_ex, wreg_ex, pcsrc_ex, br_taken_ex, mem_busy, irq,
    output stall_pc, stall_if2id, flush_if2id, flush_id2ex, irq_take
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, output flush_cnt
`endif
  );

endinterface

// File: rtl/irq_sync.sv
// Synchroniser chain for the asynchronous irq level plus a rising-edge
// detector that emits a one-cycle pulse from the last synchroniser flop.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  output logic irq_rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift irq through the synchroniser and remember the last synced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign irq_rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller with interrupt-entry sequencing.
// Priority: mem_busy freeze > taken branch > load-use > jump in ID > irq entry.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  irq_state_e state_q, state_d;
  logic       irqRise;
  logic       brTaken;
  logic       loadUse;
  logic       jumpId;
  logic       stallPc;
  logic       stallIf2id;
  logic       flushIf2id;
  logic       flushId2ex;
  logic       irqTake;

  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk        (clk),
    .reset      (reset),
    .irq_i      (bus.irq),
    .irq_rise_o (irqRise)
  );

  assign brTaken = (bus.pcsrc_ex == PCSRC_BR) && bus.br_taken_ex;
  assign loadUse = bus.memrd_ex && (bus.wreg_ex != 5'd0) &&
                   ((bus.wreg_ex == bus.rs_id) ||
                    (bus.use_rt_id && (bus.wreg_ex == bus.rt_id)));
  assign jumpId  = (bus.pcsrc_id == PCSRC_J) || (bus.pcsrc_id == PCSRC_JR) ||
                   (bus.pcsrc_id == PCSRC_ILLOP);

  // Resolve the prioritised stall/flush response and the interrupt FSM step.
  always_comb begin
    stallPc    = 1'b0;
    stallIf2id = 1'b0;
    flushIf2id = 1'b0;
    flushId2ex = 1'b0;
    irqTake    = 1'b0;
    state_d    = state_q;

    if (bus.mem_busy) begin
      stallPc    = 1'b1;
      stallIf2id = 1'b1;
    end else if (brTaken) begin
      flushIf2id = 1'b1;
      flushId2ex = 1'b1;
    end else if (loadUse) begin
      stallPc    = 1'b1;
      stallIf2id = 1'b1;
      flushId2ex = 1'b1;
    end else if (jumpId) begin
      flushIf2id = 1'b1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (irqRise) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!bus.mem_busy && !brTaken && !loadUse && !jumpId &&
            (bus.pcsrc_ex != PCSRC_BR) && (bus.pcsrc_id == PCSRC_SEQ)) begin
          irqTake    = 1'b1;
          flushIf2id = 1'b1;
          state_d    = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (bus.iret_id && (bus.pcsrc_id == PCSRC_JR) && !stallPc)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Interrupt-entry state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  assign bus.stall_pc    = stallPc    & ~reset;
  assign bus.stall_if2id = stallIf2id & ~reset;
  assign bus.flush_if2id = flushIf2id & ~reset;
  assign bus.flush_id2ex = flushId2ex & ~reset;
  assign bus.irq_take    = irqTake    & ~reset;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt_q;
  logic [31:0] flushCnt_q;

  // Count stalled cycles and flushed slots, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_q + {31'd0, stallPc};
      flushCnt_q <= flushCnt_q + {31'd0, flushIf2id} + {31'd0, flushId2ex};
    end
  end

  assign bus.stall_cnt = stallCnt_q;
  assign bus.flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; counter checks compile in only
// when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int SYNC = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.IRQ_SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rs_id       = 5'd0;
    bus.rt_id       = 5'd0;
    bus.use_rt_id   = 1'b0;
    bus.pcsrc_id    = PCSRC_SEQ;
    bus.iret_id     = 1'b0;
    bus.memrd_ex    = 1'b0;
    bus.wreg_ex     = 5'd0;
    bus.pcsrc_ex    = PCSRC_SEQ;
    bus.br_taken_ex = 1'b0;
    bus.mem_busy    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    bus.memrd_ex = 1'b1; bus.wreg_ex = 5'd8; bus.rs_id = 5'd8;
    bus.pcsrc_id = PCSRC_J;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex, bus.irq_take} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b want=00000",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex, bus.irq_take});
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
    @(negedge clk);
    idle();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    bus.memrd_ex = 1'b1; bus.wreg_ex = 5'd8; bus.rs_id = 5'd8;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b1101) begin
      failures++;
      $display("[TB] FAIL load_use_rs got=%b want=1101",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
    end
    @(negedge clk);
    bus.memrd_ex = 1'b0;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL load_use_clear got=%b want=0000",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
    end
    @(negedge clk);
    bus.memrd_ex = 1'b1; bus.wreg_ex = 5'd9; bus.rs_id = 5'd3; bus.rt_id = 5'd9;
    bus.use_rt_id = 1'b1;
    #1;
    checks++;
    if ({bus.stall_pc, bus.flush_id2ex} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL load_use_rt got=%b want=11", {bus.stall_pc, bus.flush_id2ex});
    end
    bus.use_rt_id = 1'b0;
    #1;
    checks++;
    if ({bus.stall_pc, bus.flush_id2ex} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL load_use_rt_unused got=%b want=00", {bus.stall_pc, bus.flush_id2ex});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.memrd_ex = 1'b1; bus.wreg_ex = 5'd0; bus.rs_id = 5'd0;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_id2ex} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL zero_reg got=%b want=000", {bus.stall_pc, bus.stall_if2id, bus.flush_id2ex});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    bus.pcsrc_ex = PCSRC_BR; bus.br_taken_ex = 1'b1;
    bus.memrd_ex = 1'b1; bus.wreg_ex = 5'd5; bus.rs_id = 5'd5;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL branch_beats_load got=%b want=0011",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
    end
    bus.br_taken_ex = 1'b0;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b1101) begin
      failures++;
      $display("[TB] FAIL branch_not_taken_load got=%b want=1101",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
    end
    bus.br_taken_ex = 1'b1;
    bus.mem_busy    = 1'b1;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL busy_beats_branch got=%b want=1100",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_jump();
    logic [2:0] jumps [3];
    jumps[0] = PCSRC_J; jumps[1] = PCSRC_JR; jumps[2] = PCSRC_ILLOP;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.pcsrc_id = jumps[i];
      #1;
      checks++;
      if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b0010) begin
        failures++;
        $display("[TB] FAIL jump_%0d got=%b want=0010", jumps[i],
                 {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
      end
    end
    bus.pcsrc_id = PCSRC_J;
    bus.mem_busy = 1'b1;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL jump_busy got=%b want=1100",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex});
    end
    @(negedge clk);
    idle();
  endtask

  // Raise irq at a negedge and expect a single pulse after exactly SYNC+1 posedges.
  task automatic expect_irq_pulse(input string tag);
    @(negedge clk);
    bus.irq = 1'b1;
    for (int e = 1; e <= SYNC + 3; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.irq_take !== (e == SYNC + 1)) begin
        failures++;
        $display("[TB] FAIL %s_edge%0d irq_take got=%b want=%b", tag, e, bus.irq_take, (e == SYNC + 1));
      end
    end
  endtask

  task automatic test_irq();
    bus.irq = 1'b0;
    repeat (4) @(negedge clk);
    expect_irq_pulse("irq_first");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.irq_take !== 1'b0) begin
        failures++;
        $display("[TB] FAIL irq_held_%0d irq_take got=%b want=0", i, bus.irq_take);
      end
    end
    @(negedge clk);
    bus.iret_id = 1'b1; bus.pcsrc_id = PCSRC_JR;
    #1;
    checks++;
    if ({bus.flush_if2id, bus.irq_take} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL iret_cycle got=%b want=10", {bus.flush_if2id, bus.irq_take});
    end
    @(negedge clk);
    idle();
    bus.irq = 1'b0;
    repeat (4) @(negedge clk);
    expect_irq_pulse("irq_second");
    @(negedge clk);
    bus.iret_id = 1'b1; bus.pcsrc_id = PCSRC_JR;
    @(negedge clk);
    idle();
    bus.irq = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_pend();
    @(negedge clk);
    bus.pcsrc_id = PCSRC_J;
    bus.irq      = 1'b1;
    repeat (SYNC + 3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({bus.flush_if2id, bus.irq_take} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL pend_blocked got=%b want=10", {bus.flush_if2id, bus.irq_take});
    end
    @(negedge clk);
    reset   = 1'b1;
    bus.irq = 1'b0;
    #1;
    checks++;
    if ({bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex, bus.irq_take} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL mid_pend_reset got=%b want=00000",
               {bus.stall_pc, bus.stall_if2id, bus.flush_if2id, bus.flush_id2ex, bus.irq_take});
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mid_pend_counters got=%0d/%0d want=0/0", bus.stall_cnt, bus.flush_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.irq_take !== 1'b0) begin
        failures++;
        $display("[TB] FAIL after_reset_%0d irq_take got=%b want=0", i, bus.irq_take);
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_counters();
    @(negedge clk);
    bus.memrd_ex = 1'b1; bus.wreg_ex = 5'd4; bus.rs_id = 5'd4;
    @(negedge clk);
    idle();
    bus.pcsrc_ex = PCSRC_BR; bus.br_taken_ex = 1'b1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd1 || bus.flush_cnt !== 32'd3) begin
      failures++;
      $display("[TB] FAIL counters got=%0d/%0d want=1/3", bus.stall_cnt, bus.flush_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.irq  = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_priority();
    test_jump();
    test_irq();
    test_reset_mid_pend();
`ifdef HAZARD_PERF_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage MIPS core. It produces the flush and stall strobes consumed by the IF/ID and ID/EX pipeline registers and the PC register. It inspects the instruction in ID together with the control fields already latched into the ID/EX register. It also sequences external interrupt entry, so that the pipeline is redirected to the exception vector only at a safe instruction boundary.

## Interface
Parameters:
- IRQ_SYNC_STAGES, 2, number of synchroniser flops on `irq`; legal range 2..3.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- rs_id  in  5  rs field of the instruction in ID
- rt_id  in  5  rt field of the instruction in ID
- use_rt_id  in  1  ID instruction reads rt as a source
- pcsrc_id  in  3  PCSrc decoded in ID
- iret_id  in  1  ID instruction is the interrupt-return jump
- memrd_ex  in  1  MemRd output of ID/EX
- wreg_ex  in  5  destination register of the EX instruction, after RegDst
- pcsrc_ex  in  3  PCSrc output of ID/EX
- br_taken_ex  in  1  ALU branch condition result in EX
- mem_busy  in  1  data memory not ready; freeze the whole pipeline
- irq  in  1  external interrupt, level, asynchronous to clk
- stall_pc  out  1  hold the PC
- stall_if2id  out  1  hold IF/ID
- flush_if2id  out  1  clear IF/ID to a bubble
- flush_id2ex  out  1  clear ID/EX; drives flush_ID2EX
- irq_take  out  1  redirect the PC to the interrupt vector this cycle
- stall_cnt  out  32  stall-cycle count; present only with HAZARD_PERF_CNT_EN
- flush_cnt  out  32  flushed-slot count; present only with HAZARD_PERF_CNT_EN

## Operation
- PCSrc encoding: 0 = PC+4, 1 = conditional branch, 2 = J/JAL, 3 = JR/JALR, 4 = ILLOP, 5 = IRQ vector.
- Evaluation is in strict priority order. The highest-priority match wins and lower matches are suppressed.
  1. mem_busy: stall_pc = stall_if2id = 1. No flush. FSM holds. The IRQ edge is still captured.
  2. Taken branch: pcsrc_ex == 1 and br_taken_ex. Assert flush_if2id = flush_id2ex = 1.
  3. Load-use: memrd_ex, wreg_ex != 0, and either wreg_ex == rs_id or (use_rt_id and wreg_ex == rt_id). Assert stall_pc = stall_if2id = 1 and flush_id2ex = 1.
  4. Jump in ID: pcsrc_id is 2, 3 or 4. Assert flush_if2id = 1.
  5. Interrupt entry (FSM): see below.
- FSM states are RUN, PEND and HANDLER.
  - RUN: on a synchronised rising edge of irq, go to PEND.
  - PEND: when priorities 1–4 are all inactive, pcsrc_ex != 1 and pcsrc_id == 0, assert irq_take = 1 and flush_if2id = 1 for exactly one cycle, then go to HANDLER. Otherwise stay in PEND.
  - HANDLER: new edges are ignored; nesting is not supported. Leave on iret_id = 1 with pcsrc_id == 3 and no stall that cycle, going to RUN. A level still high at that point produces no new entry; a new rising edge is required.
- Edge detection uses the last synchroniser flop and one history flop.

## Timing
- Stall and flush outputs are combinational from the current inputs and FSM state. They are valid within the same cycle and are consumed at the next posedge.
- Load-use inserts exactly one bubble. On the next cycle the ID/EX register holds MemRd = 0, so detection clears by construction.
- Branch penalty is 2 slots, both flushed. Jump penalty is 1 slot.
- irq rising edge to irq_take takes at least IRQ_SYNC_STAGES + 1 cycles when the pipeline is clean.
- Outputs while reset is asserted:
  - all stall, flush and irq_take outputs are 0;
  - FSM is in RUN;
  - synchroniser and history flops are 0;
  - counters are 0.
- Reset deasserted mid-PEND or mid-HANDLER restarts cleanly in RUN. The pending interrupt is discarded.
- A branch flush and a load-use match in the same cycle produce the branch response only, with no stall, because the load-use instruction is being killed.
- mem_busy in the same cycle as a taken branch produces a freeze only. The branch is re-evaluated when mem_busy falls.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with stall_pc = 1;
  - flush_cnt adds flush_if2id + flush_id2ex each cycle;
  - both counters wrap modulo 2^32 and clear on reset.
- HAZARD_PERF_CNT_EN undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds the PCSrc encoding constants (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_ILLOP, PCSRC_IRQ) and the FSM state enum.
- One sub-module, `irq_sync`: the parameterised synchroniser plus rising-edge detector, producing a one-cycle `irq_rise` pulse.

## Test plan
- Load-use: `lw $8` in EX (memrd_ex = 1, wreg_ex = 8) with rs_id = 8 → one cycle of stall_pc, stall_if2id and flush_id2ex; next cycle with memrd_ex = 0 → all outputs 0.
- Zero register: memrd_ex = 1, wreg_ex = 0, rs_id = 0 → no stall.
- Branch beats load-use: pcsrc_ex = 1, br_taken_ex = 1, memrd_ex = 1, wreg_ex = 5, rs_id = 5 → flush_if2id = flush_id2ex = 1 and stall_pc = 0. With br_taken_ex = 0 instead → load-use response.
- Jump: pcsrc_id = 2 → flush_if2id = 1 only. mem_busy = 1 in the same cycle → stall_pc = stall_if2id = 1 and no flush.
- Interrupt: irq rises with a clean pipeline → irq_take pulses 1 cycle exactly IRQ_SYNC_STAGES + 1 cycles later, and irq held high produces no second pulse. Then iret_id = 1 with pcsrc_id = 3 → FSM returns to RUN, and irq toggled low then high → a second pulse.
- Reset mid-PEND: assert reset during PEND → all outputs 0, and no irq_take after release. With HAZARD_PERF_CNT_EN, stall_cnt = flush_cnt = 0.
